// File: rtl/tt_fa_pkg.sv
// Shared constants for the full-adder Tiny Tapeout tile: accumulator width,
// ui_in bit positions and the fixed uio output-enable pattern.
package tt_fa_pkg;

    // Accumulator width; tied to the 8-bit uio bus of the TT pinout
    localparam int ACC_W = 8;

    // ui_in bit positions
    localparam int A_BIT   = 0;
    localparam int B_BIT   = 1;
    localparam int CIN_BIT = 2;
    localparam int CLR_BIT = 3;

    // All uio pins are driven as outputs
    localparam logic [7:0] UIO_OE_ALL = 8'hFF;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder cell, purely combinational. Used both for the
// primary user-visible adder and as the ripple element of the accumulator.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/tt_um_enjimneering_full_adder.sv
// Tiny Tapeout user tile: 1-bit full adder on ui_in[2:0] with a combinational
// result, a registered copy, and an 8-bit accumulator of {cout,sum} built
// from a ripple chain of the same full-adder cell.
module tt_um_enjimneering_full_adder
    import tt_fa_pkg::*;
(
`ifdef GL_TEST
    inout  wire        VPWR,
    inout  wire        VGND,
`endif
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic a;
    logic b;
    logic cin;
    logic acc_clr;
    logic sum;
    logic cout;

    logic sum_p1;
    logic cout_p1;
    logic [ACC_W-1:0] acc_p1;

    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   carry;

    // Only ui_in[3:0] are decoded; upper ui_in bits and uio_in never reach
    // any logic, so X on them cannot leak to an output.
    logic unused_ok;

    assign a       = ui_in[A_BIT];
    assign b       = ui_in[B_BIT];
    assign cin     = ui_in[CIN_BIT];
    assign acc_clr = ui_in[CLR_BIT];

    full_adder_cell u_fa (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // Ripple-carry adder: acc + {0..0, cout, sum}, carry-in 0; the final
    // carry-out is dropped so the accumulator wraps modulo 2^ACC_W.
    assign addend   = {{(ACC_W-2){1'b0}}, cout, sum};
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < ACC_W; i++) begin : g_acc_chain
        full_adder_cell u_cell (
            .a    (acc_p1[i]),
            .b    (addend[i]),
            .cin  (carry[i]),
            .sum  (acc_next[i]),
            .cout (carry[i+1])
        );
    end

    // Registered stage: reset > enable hold > accumulator clear > update
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sum_p1  <= 1'b0;
            cout_p1 <= 1'b0;
            acc_p1  <= '0;
        end else if (ena) begin
            sum_p1  <= sum;
            cout_p1 <= cout;
            acc_p1  <= acc_clr ? '0 : acc_next;
        end
    end

    assign uo_out  = {4'b0000, cout_p1, sum_p1, cout, sum};
    assign uio_out = acc_p1;
    assign uio_oe  = UIO_OE_ALL;

    assign unused_ok = &{1'b0, ui_in[7:4], uio_in, carry[ACC_W]};

endmodule

// File: tb/tb_tt_um_enjimneering_full_adder.sv
module tb_tt_um_enjimneering_full_adder;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int checks;
    int errors;

    // Reference state (what the registers should hold)
    int m_sum_q;
    int m_cout_q;
    int m_acc;

    tt_um_enjimneering_full_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always begin
        #5;
        clk = clk_run ? ~clk : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: number of ones among a, b, cin
    function automatic int add3(input logic [7:0] ui);
        return int'(ui[0]) + int'(ui[1]) + int'(ui[2]);
    endfunction

    // Check the combinational result against the current inputs
    task automatic chk_comb(input string tag);
        int s;
        s = add3(ui_in);
        chk({tag, ".sum"},  {31'b0, uo_out[0]}, s % 2);
        chk({tag, ".cout"}, {31'b0, uo_out[1]}, s / 2);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".sum_q"},  {31'b0, uo_out[2]}, m_sum_q);
        chk({tag, ".cout_q"}, {31'b0, uo_out[3]}, m_cout_q);
        chk({tag, ".acc"},    {24'b0, uio_out},   m_acc);
        chk({tag, ".hi"},     {28'b0, uo_out[7:4]}, 0);
        chk({tag, ".oe"},     {24'b0, uio_oe},    32'hFF);
    endtask

    // One clock with the current inputs; model updated from the rules,
    // outputs compared 1 time unit after the rising edge.
    task automatic cycle(input string tag, input bit do_check);
        int s;
        s = add3(ui_in);
        if (rst_n) begin
            m_sum_q = 0; m_cout_q = 0; m_acc = 0;
        end else if (ena) begin
            m_sum_q  = s % 2;
            m_cout_q = s / 2;
            m_acc    = ui_in[3] ? 0 : (m_acc + s) % 256;
        end
        @(posedge clk);
        #1;
        if (do_check) begin
            chk_regs(tag);
            chk_comb(tag);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_sum_q = 0; m_cout_q = 0; m_acc = 0;
        clk_run = 1'b0;
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // 1. combinational sweep with clock idle
        for (int i = 0; i < 8; i++) begin
            ui_in = 8'(i);
            #20;
            chk($sformatf("sweep%0d", i), {30'b0, uo_out[1:0]}, add3(ui_in));
        end

        // 2. reset two cycles, then first update after release
        clk_run = 1'b1;
        ena = 1'b1;
        ui_in = 8'h05;
        cycle("rst1", 1'b1);
        cycle("rst2", 1'b1);
        rst_n = 1'b0;
        ui_in = 8'h03;
        cycle("rel", 1'b1);
        chk("rel.q", {30'b0, uo_out[3:2]}, 32'h2);

        // 3. five cycles of 7 from zero -> 0F
        rst_n = 1'b1;
        cycle("clr", 1'b0);
        rst_n = 1'b0;
        ui_in = 8'h07;
        for (int i = 0; i < 5; i++) cycle("acc7", 1'b1);
        chk("acc0F", {24'b0, uio_out}, 32'h0F);

        // 4. wrap: reach FE, add 3 -> 01, then clear with cin set -> 00
        ui_in = 8'h0F;
        cycle("clr2", 1'b0);
        ui_in = 8'h07;
        for (int i = 0; i < 84; i++) cycle("to252", 1'b0);
        ui_in = 8'h03;
        cycle("to254", 1'b1);
        chk("accFE", {24'b0, uio_out}, 32'hFE);
        ui_in = 8'h07;
        cycle("wrap", 1'b1);
        chk("acc01", {24'b0, uio_out}, 32'h01);
        ui_in = 8'h0F;
        cycle("aclr", 1'b1);
        chk("acc00", {24'b0, uio_out}, 32'h00);

        // 5. hold with ena=0 while inputs toggle
        ui_in = 8'h06;
        cycle("pre", 1'b1);
        ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ui_in = (i % 2 == 0) ? 8'h00 : 8'h07;
            cycle("hold", 1'b1);
        end
        chk("hold.acc", {24'b0, uio_out}, 32'h02);
        ena = 1'b1;

        // 6. reset mid-accumulation at acc=20, then X on unused inputs
        ui_in = 8'h0F;
        cycle("clr3", 1'b0);
        ui_in = 8'h07;
        for (int i = 0; i < 10; i++) cycle("to30", 1'b0);
        ui_in = 8'h03;
        cycle("to32", 1'b1);
        chk("acc20", {24'b0, uio_out}, 32'h20);
        rst_n = 1'b1;
        cycle("midrst", 1'b1);
        chk("midrst.acc", {24'b0, uio_out}, 32'h00);
        rst_n = 1'b0;
        ui_in  = {4'bxxxx, 4'b0111};
        uio_in = 8'bxxxxxxxx;
        cycle("xin", 1'b1);
        chk("xin.uo",  {31'b0, $isunknown(uo_out)},  0);
        chk("xin.uio", {31'b0, $isunknown(uio_out)}, 0);
        uio_in = 8'h00;

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            ui_in = 8'($urandom);
            ui_in[3] = ($urandom_range(0, 15) == 0);
            ena   = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 31) == 0);
            cycle("rand", 1'b1);
        end

        clk_run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
